acc_output_fifo: RTL and testbench
==================================

# acc_output_fifo

Downstream capture stage for the accumulator processor's 16-bit `Output` bus. It samples the bus every clock and enqueues a value whenever the bus changes, so no intermediate result is lost. Queued values drain to a display or host consumer through a valid/ready handshake. The block connects directly to `accumulatorFull.Output` and shares its clock and reset.

## Interface
- `WIDTH`, 16, data width; matches the processor `Output` bus.
- `DEPTH`, 4, FIFO entries; a power of two, at least 2.
- `CLK`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset, same net as the processor reset.
- `AccOut`  in  WIDTH  processor `Output` bus, sampled every cycle.
- `OutReady`  in  1  consumer can accept `OutData` this cycle.
- `OutData`  out  WIDTH  head-of-queue value; forced to 0 when `OutValid`=0.
- `OutValid`  out  1  queue non-empty; `OutData` is meaningful.
- `Count`  out  log2(DEPTH)+1  number of entries currently queued.
- `Overflow`  out  1  sticky flag: a change was dropped because the queue was full.

## Operation
- Registers:
  - `LastVal[WIDTH]`: previous sample.
  - `Primed`: a first sample has been taken since reset.
  - storage array of DEPTH entries.
  - `WrPtr` and `RdPtr`, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - `Count`.
  - `Overflow`.
- Reset (`reset`=1 at an edge) sets `Primed`=0, both pointers=0, `Count`=0 and `Overflow`=0.
  - `LastVal` and the storage array are not reset.
  - While reset is held, pushes and pops are suppressed.
- Change detect: `Change` = !`Primed` OR (`AccOut` != `LastVal`).
  - The first non-reset edge therefore always enqueues.
  - Every non-reset edge loads `LastVal`<=`AccOut` and sets `Primed`<=1.
- Push request = `Change`. Pop = `OutValid` AND `OutReady`.
- Push and pop combinations:
  - Push, not full: write `AccOut` at `WrPtr`, increment `WrPtr`.
  - Push while full, no pop: drop the value, set `Overflow`<=1. Pointers and `Count` are unchanged. `LastVal` still updates, so the dropped value is not re-detected.
  - Push while full, with pop: both occur and `Count` stays at DEPTH. Full is judged before the pop, but a simultaneous pop frees the slot.
  - Pop: increment `RdPtr`.
- `Count` update: +1 for push only, -1 for pop only, unchanged for both or neither.
- `OutValid` = (`Count` != 0). `OutData` = storage[`RdPtr`] when valid, else 0. Both are combinational from registers; no combinational path from any input.
- No bypass: a value pushed into an empty queue is visible only after the push edge.
- `Overflow` clears only on reset.
- X on `AccOut` while the processor is in reset is harmless because pushes are suppressed during reset.

## Timing
- Reset values after the reset edge: `OutValid`=0, `OutData`=0, `Count`=0, `Overflow`=0.
- Latency: a value on `AccOut` at edge N gives `OutValid`=1 with `OutData` = that value after edge N, when the queue was empty.
- Handshake:
  - Transfer occurs at an edge where `OutValid` AND `OutReady` are both high.
  - The next entry, or 0 with `OutValid`=0, appears after that edge.
  - `OutReady` may toggle freely.
  - `OutData` and `OutValid` are stable between edges.
- Throughput: one push and one pop per cycle, sustained.
- Reset mid-operation discards all entries at that edge. The first post-reset edge re-enqueues the current `AccOut` (`Primed`=0).
- A held `AccOut` produces exactly one entry, no matter how many cycles it is held.

## Test plan
- Reset for 3 cycles, then hold `AccOut`=16'hff00 with `OutReady`=0 for 5 cycles.
  - Exactly one entry is queued: `Count`=1, `OutData`=16'hff00, `Overflow`=0.
- Continuing, step `AccOut` through 0001, 0002, 0003, one per cycle, with `OutReady`=0.
  - `Count`=4 (full).
- Then drive 0004.
  - `Overflow`=1 and `Count` stays 4.
- Raise `OutReady`.
  - Drains ff00, 0001, 0002, 0003 on consecutive edges.
  - `OutValid`=0 and `OutData`=0 after that.
- Full queue, `OutReady`=1, new `AccOut` value 0x1234 on the same edge.
  - Head pops, 0x1234 is written at the tail, `Count` remains 4, `Overflow` is unchanged.
- Empty queue, `OutReady`=1 held high, `AccOut` changes every cycle through 0xA000..0xA007.
  - Each value appears one cycle after it is sampled.
  - `Count` never exceeds 1, all 8 values are received in order, no drops.
- Queue holds 3 entries and reset is asserted for 1 cycle while `AccOut`=0x0042.
  - After the reset edge, `Count`=0 and `OutValid`=0.
  - After the next edge, `Count`=1 with `OutData`=0x0042.
  - `Overflow` is cleared.

Source files
------------

// File: rtl/acc_output_fifo.sv
// Capture FIFO for the accumulator processor Output bus: enqueues every change
// of the bus and drains it to a consumer through a valid/ready handshake.
module acc_output_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         AccOut,
   input  logic                     OutReady,
   output logic [WIDTH-1:0]         OutData,
   output logic                     OutValid,
   output logic [$clog2(DEPTH):0]   Count,
   output logic                     Overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] last_val_q;
   logic             primed_q;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             overflow_q, overflow_d;

   logic change;
   logic full;
   logic pop;
   logic push;

   // Change detection is against the last sample, not the last enqueued value,
   // so a value dropped on overflow is not retried on the following cycle.
   assign change = !primed_q || (AccOut != last_val_q);
   assign full   = (count_q == FULL_CNT);
   assign pop    = OutValid && OutReady;
   assign push   = change && (!full || pop);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + (AW+1)'(1);
      else if (pop && !push) count_d = count_q - (AW+1)'(1);
      if (change && full && !pop) overflow_d = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (reset) begin
         primed_q   <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         primed_q   <= 1'b1;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // NOTE: storage and the last sample carry no reset; they are only observed once the control state says they are valid.
   always_ff @(posedge CLK) begin
      if (!reset) begin
         last_val_q <= AccOut;
         if (push) mem_q[wr_ptr_q] <= AccOut;
      end
   end

   assign OutValid = (count_q != '0);
   assign OutData  = OutValid ? mem_q[rd_ptr_q] : '0;
   assign Count    = count_q;
   assign Overflow = overflow_q;

   a_count_bound : assert property (@(posedge CLK) disable iff (reset) count_q <= FULL_CNT);

endmodule

// File: tb/tb_acc_output_fifo.sv
// Self-checking bench for acc_output_fifo: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_acc_output_fifo;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;

   logic             CLK = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] AccOut;
   logic             OutReady;
   logic [WIDTH-1:0] OutData;
   logic             OutValid;
   logic [2:0]       Count;
   logic             Overflow;

   int n_checks = 0;
   int n_fail   = 0;

   logic [WIDTH-1:0] mq [$];
   logic [WIDTH-1:0] m_last;
   bit               m_primed = 0;
   bit               m_ovf    = 0;

   acc_output_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK      (CLK),
      .reset    (reset),
      .AccOut   (AccOut),
      .OutReady (OutReady),
      .OutData  (OutData),
      .OutValid (OutValid),
      .Count    (Count),
      .Overflow (Overflow)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Reference behaviour of one clock edge.
   task automatic model_edge(input logic [WIDTH-1:0] acc, input bit rdy, input bit rst);
      bit chg, was_full, do_pop;
      if (rst) begin
         mq.delete();
         m_primed = 0;
         m_ovf    = 0;
         return;
      end
      chg      = !m_primed || (acc != m_last);
      was_full = (mq.size() == DEPTH);
      do_pop   = (mq.size() != 0) && rdy;
      if (do_pop) void'(mq.pop_front());
      if (chg) begin
         if (!was_full || do_pop) mq.push_back(acc);
         else                     m_ovf = 1;
      end
      m_last   = acc;
      m_primed = 1;
   endtask

   task automatic step(input logic [WIDTH-1:0] acc, input bit rdy, input bit rst);
      AccOut   = acc;
      OutReady = rdy;
      reset    = rst;
      @(posedge CLK);
      model_edge(acc, rdy, rst);
      #1;
      check("count",    32'(Count),    32'(mq.size()));
      check("valid",    32'(OutValid), 32'(mq.size() != 0));
      check("data",     32'(OutData),  (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
      check("overflow", 32'(Overflow), 32'(m_ovf));
   endtask

   initial begin
      logic [WIDTH-1:0] drain_exp [4];

      // Initial reset, bus undefined while the processor is in reset.
      for (int i = 0; i < 3; i++) step('x, 0, 1);
      check("rst_count", 32'(Count), 0);
      check("rst_valid", 32'(OutValid), 0);
      check("rst_data",  32'(OutData), 0);
      check("rst_ovf",   32'(Overflow), 0);

      // Held value yields exactly one entry.
      for (int i = 0; i < 5; i++) step(16'hff00, 0, 0);
      check("hold_count", 32'(Count), 1);
      check("hold_data",  32'(OutData), 32'h0000ff00);
      check("hold_ovf",   32'(Overflow), 0);

      for (int i = 1; i <= 3; i++) step(16'(i), 0, 0);
      check("fill_count", 32'(Count), 4);

      step(16'h0004, 0, 0);
      check("drop_ovf",   32'(Overflow), 1);
      check("drop_count", 32'(Count), 4);

      drain_exp = '{16'hff00, 16'h0001, 16'h0002, 16'h0003};
      for (int i = 0; i < 4; i++) begin
         check("drain_head", 32'(OutData), 32'(drain_exp[i]));
         step(16'h0004, 1, 0);
      end
      check("drain_valid", 32'(OutValid), 0);
      check("drain_data",  32'(OutData), 0);

      // Push into a full queue with a simultaneous pop.
      for (int i = 0; i < 4; i++) step(16'h0010 + 16'(i), 0, 0);
      check("full2_count", 32'(Count), 4);
      step(16'h1234, 1, 0);
      check("pp_count", 32'(Count), 4);
      check("pp_head",  32'(OutData), 32'h00000011);
      check("pp_ovf",   32'(Overflow), 1);
      drain_exp = '{16'h0011, 16'h0012, 16'h0013, 16'h1234};
      for (int i = 0; i < 4; i++) begin
         check("pp_drain", 32'(OutData), 32'(drain_exp[i]));
         step(16'h1234, 1, 0);
      end
      check("pp_empty", 32'(OutValid), 0);

      // Streaming through an empty queue: one-cycle latency, no build-up.
      for (int i = 0; i < 8; i++) begin
         step(16'hA000 + 16'(i), 1, 0);
         check("stream_data",  32'(OutData), 32'hA000 + 32'(i));
         check("stream_count", 32'(Count), 1);
      end
      step(16'hA007, 1, 0);
      check("stream_empty", 32'(OutValid), 0);

      // Reset mid-operation with three entries queued.
      for (int i = 0; i < 3; i++) step(16'h0030 + 16'(i), 0, 0);
      check("pre_rst_count", 32'(Count), 3);
      step(16'h0042, 0, 1);
      check("mid_rst_count", 32'(Count), 0);
      check("mid_rst_valid", 32'(OutValid), 0);
      check("mid_rst_ovf",   32'(Overflow), 0);
      step(16'h0042, 0, 0);
      check("post_rst_count", 32'(Count), 1);
      check("post_rst_data",  32'(OutData), 32'h00000042);

      // Random traffic: small value alphabet so holds and repeats are common.
      for (int i = 0; i < 600; i++) begin
         logic [WIDTH-1:0] v;
         v = 16'h5500 + 16'($urandom_range(0, 3));
         step(v, bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 59) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
